medidor_frecuencia: RTL and testbench
=====================================

# medidor_frecuencia

Frequency meter that consumes the variable square wave produced by the adjustable-frequency generator stage (its SALIDA output) and measures it with a fixed gate window. It counts rising edges per gate, converts the count to four BCD digits with a sequential double-dabble, and presents binary plus BCD results with a one-cycle valid strobe. It sits directly downstream of the generator and feeds the 7-segment multiplexer so the board displays the measured frequency rather than the set point.

## Interface
- GATE_CYCLES, 50_000_000: gate window length in CLK cycles; 1 s at 50 MHz, so the count equals Hz. The minimum is 32.
- MAX_CUENTA, 9999: saturation value, the largest count displayable on 4 digits.
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- SENAL_IN  in  1  measured signal; asynchronous to CLK.
- FRECUENCIA  out  14  last completed measurement, binary, saturated at MAX_CUENTA.
- UNID  out  4  BCD units digit of FRECUENCIA.
- DECE  out  4  BCD tens digit.
- CENT  out  4  BCD hundreds digit.
- MILL  out  4  BCD thousands digit.
- VALIDO  out  1  one-cycle pulse when all result outputs update.
- SOBRERANGO  out  1  set when the last measurement reached MAX_CUENTA or beyond; held until the next result.

## Operation
- Input path:
  - SENAL_IN passes through a 2-FF synchronizer, then a third register for edge detection.
  - A rising edge (EDGE) is sync=1 and prev=0.
- Gate counter:
  - Free-running from 0 to GATE_CYCLES-1, then wraps to 0.
  - The cycle at GATE_CYCLES-1 is the closing cycle.
- Edge counter:
  - 14 bits, increments on EDGE and saturates at MAX_CUENTA.
  - A sticky over flag sets when EDGE arrives while the counter already equals MAX_CUENTA, or when the increment reaches MAX_CUENTA.
- Closing cycle:
  - The snapshot equals the edge count plus an EDGE occurring in the closing cycle, saturated.
  - The snapshot and over flag pass to the converter.
  - The edge counter and over flag clear to 0, so the next window starts empty.
  - An EDGE in the closing cycle belongs to the closing window only.
- Converter FSM, states CONV_LIBRE, CONV_CARGA, CONV_DESPL, CONV_FIN:
  - CONV_LIBRE: waits for the closing-cycle snapshot and moves to CONV_CARGA.
  - CONV_CARGA: loads a 14-bit shift register, clears the 16-bit BCD accumulator, sets the iteration counter to 13, then moves to CONV_DESPL.
  - CONV_DESPL (14 cycles): in each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1. When the iteration counter reaches 0, move to CONV_FIN.
  - CONV_FIN: registers the outputs, pulses VALIDO, and returns to CONV_LIBRE.
- Conversion (16 cycles) always finishes long before the next closing cycle, since GATE_CYCLES ≥ 32. No snapshot is ever dropped.
- Outputs hold their values between VALIDO pulses.

## Timing
- Reset values:
  - FRECUENCIA, UNID, DECE, CENT and MILL are 0.
  - VALIDO and SOBRERANGO are 0.
  - The gate counter, edge counter, synchronizer and edge registers are 0.
  - The FSM is in CONV_LIBRE.
- Edge latency: an EDGE is recognised 3 CLK edges after SENAL_IN rises, when the input meets setup.
- Result latency: with the closing cycle at clock edge T, VALIDO is high during the cycle after edge T+16. All result outputs change on that same edge.
- First VALIDO after reset: GATE_CYCLES+16 cycles after RST deasserts. The first window is always a full window.
- Mid-operation reset: RST high in any cycle aborts the conversion, clears every register and output, and suppresses VALIDO. Counting restarts from cycle 0 after RST falls.
- Boundary conditions:
  - Zero edges in a window gives FRECUENCIA=0 with digits 0,0,0,0.
  - Exactly MAX_CUENTA edges gives 9999 and SOBRERANGO=1.
  - More than MAX_CUENTA edges gives 9999 and SOBRERANGO=1.
- Input pulses narrower than 2 CLK periods may be missed. Inputs from the generator (≤2 kHz) are always far wider.

## Test plan
- GATE_CYCLES=1000, SENAL_IN period 100 CLK at 50 % duty, started 10 cycles after reset -> first VALIDO at cycle 1016 after reset; FRECUENCIA=10; MILL/CENT/DECE/UNID = 0/0/1/0; SOBRERANGO=0.
- GATE_CYCLES=1000, SENAL_IN held 0 -> VALIDO every 1000 cycles; FRECUENCIA=0; all digits 0.
- GATE_CYCLES=50000, SENAL_IN period 4 CLK (12500 edges) -> FRECUENCIA=9999; digits 9/9/9/9; SOBRERANGO=1. Next window with 25-cycle period (2000 edges) -> 2000; digits 2/0/0/0; SOBRERANGO=0.
- GATE_CYCLES=1000, a single SENAL_IN rise placed so EDGE falls exactly on the closing cycle -> that window reports 1; the following window reports 0.
- GATE_CYCLES=1000, period 100 input, RST pulsed 1 cycle at cycle 1005 (mid-conversion) -> no VALIDO near 1016; all outputs 0 after reset; next VALIDO at cycle 1006+1016 with FRECUENCIA=10.
- GATE_CYCLES=40000, input period 31 CLK (1290 edges) -> FRECUENCIA=1290; digits 1/2/9/0; VALIDO exactly one cycle wide.

Source files
------------

// File: rtl/medidor_frecuencia.sv
// rtl/medidor_frecuencia.sv - gated rising-edge frequency meter with sequential binary-to-BCD conversion
module medidor_frecuencia #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int MAX_CUENTA  = 9999
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SENAL_IN,
    output logic [13:0] FRECUENCIA,
    output logic [3:0]  UNID,
    output logic [3:0]  DECE,
    output logic [3:0]  CENT,
    output logic [3:0]  MILL,
    output logic        VALIDO,
    output logic        SOBRERANGO
);

    localparam int              GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [13:0]     MAXC      = 14'(MAX_CUENTA);

    typedef enum logic [1:0] {
        CONV_LIBRE,
        CONV_CARGA,
        CONV_DESPL,
        CONV_FIN
    } estado_t;

    logic          sync1, sync2, prev;
    logic          flanco;
    logic [GW-1:0] gate_cnt;
    logic          cierre;
    logic [13:0]   cuenta, cuenta_inc, cuenta_sig;
    logic          sobre, sobre_sig;
    logic [13:0]   snap;
    logic          snap_sobre;
    estado_t       estado, estado_sig;
    logic [13:0]   bin;
    logic [15:0]   bcd, bcd_aj;
    logic [3:0]    iter;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= SENAL_IN;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign flanco = sync2 & ~prev;
    assign cierre = (gate_cnt == GATE_LAST);

    always_ff @(posedge CLK) begin
        if (RST || cierre) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // Next count including this cycle's edge; the closing snapshot uses it so
    // an edge in the closing cycle lands in the window being closed.
    always_comb begin
        cuenta_inc = (cuenta == MAXC) ? MAXC : cuenta + 14'd1;
        cuenta_sig = flanco ? cuenta_inc : cuenta;
        sobre_sig  = sobre | (flanco & ((cuenta == MAXC) | (cuenta + 14'd1 == MAXC)));
    end

    always_ff @(posedge CLK) begin
        if (RST || cierre) begin
            cuenta <= '0;
            sobre  <= 1'b0;
        end else begin
            cuenta <= cuenta_sig;
            sobre  <= sobre_sig;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            snap       <= '0;
            snap_sobre <= 1'b0;
        end else if (cierre) begin
            snap       <= cuenta_sig;
            snap_sobre <= sobre_sig;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            estado <= CONV_LIBRE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            CONV_LIBRE: if (cierre) estado_sig = CONV_CARGA;
            CONV_CARGA: estado_sig = CONV_DESPL;
            CONV_DESPL: if (iter == 4'd0) estado_sig = CONV_FIN;
            CONV_FIN:   estado_sig = CONV_LIBRE;
            default:    estado_sig = CONV_LIBRE;
        endcase
    end

    // Double-dabble correction applied before every shift.
    always_comb begin
        bcd_aj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bin        <= '0;
            bcd        <= '0;
            iter       <= '0;
            FRECUENCIA <= '0;
            UNID       <= '0;
            DECE       <= '0;
            CENT       <= '0;
            MILL       <= '0;
            VALIDO     <= 1'b0;
            SOBRERANGO <= 1'b0;
        end else begin
            VALIDO <= 1'b0;
            case (estado)
                CONV_CARGA: begin
                    bin  <= snap;
                    bcd  <= '0;
                    iter <= 4'd13;
                end
                CONV_DESPL: begin
                    {bcd, bin} <= {bcd_aj[14:0], bin, 1'b0};
                    iter       <= iter - 4'd1;
                end
                CONV_FIN: begin
                    FRECUENCIA <= snap;
                    MILL       <= bcd[15:12];
                    CENT       <= bcd[11:8];
                    DECE       <= bcd[7:4];
                    UNID       <= bcd[3:0];
                    SOBRERANGO <= snap_sobre;
                    VALIDO     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb/tb_medidor_frecuencia.sv - randomized bench with window-count reference model for medidor_frecuencia
module tb_medidor_frecuencia;

    localparam int G     = 1000;
    localparam int MAX_A = 9999;
    localparam int MAX_B = 150;
    localparam int LMAX  = 2200;

    logic        CLK = 1'b0;
    logic        RST;
    logic        SENAL_IN;
    logic [13:0] frec_a, frec_b;
    logic [3:0]  un_a, de_a, ce_a, mi_a, un_b, de_b, ce_b, mi_b;
    logic        val_a, val_b, ov_a, ov_b;

    int checks   = 0;
    int failures = 0;

    logic wav [0:LMAX-1];
    int   res_raw [0:2];
    int   c_cur    = 0;
    bit   en_check = 1'b0;
    int   pin_mode = 0;

    always #5 CLK = ~CLK;

    medidor_frecuencia #(.GATE_CYCLES(G), .MAX_CUENTA(MAX_A)) dut_a (
        .CLK(CLK), .RST(RST), .SENAL_IN(SENAL_IN),
        .FRECUENCIA(frec_a), .UNID(un_a), .DECE(de_a), .CENT(ce_a), .MILL(mi_a),
        .VALIDO(val_a), .SOBRERANGO(ov_a)
    );

    medidor_frecuencia #(.GATE_CYCLES(G), .MAX_CUENTA(MAX_B)) dut_b (
        .CLK(CLK), .RST(RST), .SENAL_IN(SENAL_IN),
        .FRECUENCIA(frec_b), .UNID(un_b), .DECE(de_b), .CENT(ce_b), .MILL(mi_b),
        .VALIDO(val_b), .SOBRERANGO(ov_b)
    );

    // A rise sampled in cycle k counts as an edge in cycle k+2; the window is
    // decided by the cycle the edge is seen in. Input before reset release is 0.
    function automatic int count_window(int w, int len);
        int n = 0;
        for (int c = w * G; c < w * G + G; c++) begin
            if (c >= 2 && c - 2 < len) begin
                if (wav[c-2] && (c < 3 || !wav[c-3])) n++;
            end
        end
        return n;
    endfunction

    task automatic cmp_dut(input string nm, input int m, input logic v, input logic o,
                           input logic [13:0] f, input logic [3:0] mi, input logic [3:0] ce,
                           input logic [3:0] de, input logic [3:0] un);
        int ev, eo, ef, raw, w;
        ev = 0; eo = 0; ef = 0;
        if (c_cur >= G + 16) begin
            w   = (c_cur - G - 16) / G;
            raw = res_raw[w];
            ef  = (raw > m) ? m : raw;
            eo  = (raw >= m) ? 1 : 0;
            ev  = ((c_cur - G - 16) % G == 0) ? 1 : 0;
        end
        checks++;
        if (int'(v) != ev || int'(o) != eo || int'(f) != ef || int'(mi) != (ef / 1000) % 10 ||
            int'(ce) != (ef / 100) % 10 || int'(de) != (ef / 10) % 10 || int'(un) != ef % 10) begin
            failures++;
            $display("FAIL %s cycle=%0d actual v=%0d o=%0d f=%0d digits=%0d%0d%0d%0d expected v=%0d o=%0d f=%0d",
                     nm, c_cur, v, o, f, mi, ce, de, un, ev, eo, ef);
        end
    endtask

    always @(negedge CLK) begin
        if (en_check) begin
            cmp_dut("dut_a", MAX_A, val_a, ov_a, frec_a, mi_a, ce_a, de_a, un_a);
            cmp_dut("dut_b", MAX_B, val_b, ov_b, frec_b, mi_b, ce_b, de_b, un_b);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, c_cur, act, exp);
        end
    endtask

    task automatic check_pins(input int c);
        case (pin_mode)
            1: begin
                if (c == 1015) chk("p1_valido_before", val_a, 0);
                if (c == 1016) begin
                    chk("p1_valido", val_a, 1);
                    chk("p1_frec", frec_a, 10);
                    chk("p1_digits", {mi_a, ce_a, de_a, un_a}, 16'h0010);
                    chk("p1_sobre", ov_a, 0);
                end
                if (c == 1017) chk("p1_valido_width", val_a, 0);
            end
            2: begin
                if (c == 1016) chk("edge_on_close", frec_a, 1);
                if (c == 2016) chk("next_window_empty", frec_a, 0);
            end
            3: begin
                if (c == 1016) begin
                    chk("sat_b_frec", frec_b, 150);
                    chk("sat_b_sobre", ov_b, 1);
                    chk("sat_a_digits", {mi_a, ce_a, de_a, un_a}, 16'h0250);
                end
            end
            4: begin
                if (c == 0) chk("after_reset_frec", frec_a, 0);
                if (c == 1016) chk("after_reset_valido", val_a, 1);
            end
            5: begin
                if (c == 1016) begin
                    chk("exact_max_b", frec_b, 150);
                    chk("exact_max_b_sobre", ov_b, 1);
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset(input int n);
        en_check = 1'b0;
        RST      = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_phase(input int len, input int pm);
        pin_mode = pm;
        for (int w = 0; w < 3; w++) res_raw[w] = count_window(w, len);
        for (int c = 0; c < len; c++) begin
            c_cur    = c;
            RST      = 1'b0;
            SENAL_IN = wav[c];
            en_check = 1'b1;
            @(negedge CLK);
            check_pins(c);
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int p, h, off, run;
        logic lvl;
        RST      = 1'b1;
        SENAL_IN = 1'b0;
        @(posedge CLK);
        #1;
        do_reset(3);

        for (int c = 0; c < LMAX; c++) wav[c] = (c >= 10) && (((c - 10) % 100) < 50);
        run_phase(2100, 1);

        do_reset(2);
        for (int c = 0; c < LMAX; c++) wav[c] = 1'b0;
        run_phase(2100, 0);

        do_reset(2);
        for (int c = 0; c < LMAX; c++) wav[c] = (c % 4) < 2;
        run_phase(2100, 3);

        do_reset(2);
        for (int c = 0; c < LMAX; c++) wav[c] = (c >= 997) && (c < 1050);
        run_phase(2100, 2);

        do_reset(2);
        for (int c = 0; c < LMAX; c++) wav[c] = (c % 100) < 50;
        run_phase(1005, 0);
        do_reset(1);
        run_phase(2100, 4);

        for (int k = 149; k <= 150; k++) begin
            do_reset(2);
            for (int c = 0; c < LMAX; c++) wav[c] = (c < 6 * k) && ((c % 6) < 3);
            run_phase(1100, (k == 150) ? 5 : 0);
        end

        for (int r = 0; r < 4; r++) begin
            do_reset(2);
            p   = $urandom_range(80, 4);
            h   = $urandom_range(p - 2, 2);
            off = $urandom_range(p - 1, 0);
            for (int c = 0; c < LMAX; c++) wav[c] = ((c + off) % p) < h;
            run_phase(2100, 0);
        end

        for (int r = 0; r < 2; r++) begin
            do_reset(2);
            lvl = 1'($urandom_range(1, 0));
            run = $urandom_range(25, 2);
            for (int c = 0; c < LMAX; c++) begin
                wav[c] = lvl;
                run--;
                if (run == 0) begin
                    lvl = ~lvl;
                    run = $urandom_range(25, 2);
                end
            end
            run_phase(2100, 0);
        end

        en_check = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
